// File: rtl/gemm_array_ctrl_if.sv
// Command, operand-feed and result-drain signals of the GEMM array sequencer.
// master: the sequencer (gemm_array_ctrl). slave: the surrounding datapath
// and the command/result agent.
// Optional macro GEMM_ARRAY_CTRL_PERF_EN adds the perf_cycles counter output.
interface gemm_array_ctrl_if #(
  parameter int ARRAY_N = 4,
  parameter int K_W     = 8
);
  localparam int ROW_W = $clog2(ARRAY_N);

  // Command side
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   busy;
  logic                   done;

  // Array control and operand-buffer feed
  logic                   pe_clear;
  logic [ARRAY_N-1:0]     feed_en;
  logic [ARRAY_N*K_W-1:0] feed_idx;

  // Result drain handshake
  logic                   c_valid;
  logic                   c_ready;
  logic [ROW_W-1:0]       c_row;

`ifdef GEMM_ARRAY_CTRL_PERF_EN
  logic [31:0]            perf_cycles;

  modport master (
    input  start, k_len, c_ready,
    output busy, done, pe_clear, feed_en, feed_idx, c_valid, c_row, perf_cycles
  );

  modport slave (
    output start, k_len, c_ready,
    input  busy, done, pe_clear, feed_en, feed_idx, c_valid, c_row, perf_cycles
  );
`else
  modport master (
    input  start, k_len, c_ready,
    output busy, done, pe_clear, feed_en, feed_idx, c_valid, c_row
  );

  modport slave (
    output start, k_len, c_ready,
    input  busy, done, pe_clear, feed_en, feed_idx, c_valid, c_row
  );
`endif

endinterface

// File: rtl/gemm_array_ctrl.sv
// Sequencer for an ARRAY_N x ARRAY_N output-stationary systolic GEMM array.
// A start command clears the PE accumulators, walks a skewed operand feed
// across the rows/columns, waits for the wavefront to flush, drains one
// result row per valid/ready beat and pulses done.
// Optional macro GEMM_ARRAY_CTRL_PERF_EN adds a saturating busy-cycle counter.
module gemm_array_ctrl #(
  parameter int ARRAY_N = 4,
  parameter int K_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  gemm_array_ctrl_if.master bus
);

  // Cycle counter wide enough for K_max + ARRAY_N - 2 without wrapping.
  localparam int CNT_W = K_W + $clog2(ARRAY_N) + 1;
  localparam int ROW_W = $clog2(ARRAY_N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(ARRAY_N);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_N - 1);

  logic [2:0]       state_q, state_d;
  logic [K_W-1:0]   k_q,     k_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ROW_W-1:0] row_q,   row_d;

  logic             start_acc;
  logic [CNT_W-1:0] k_ext;
  logic [CNT_W-1:0] feed_last;
  logic [ARRAY_N-1:0]     feed_en_w;
  logic [ARRAY_N*K_W-1:0] feed_idx_w;

  // A start is taken only in IDLE and only for a non-empty inner dimension.
  assign start_acc = (state_q == S_IDLE) && bus.start && (bus.k_len != '0);

  // Last FEED value of t is K+ARRAY_N-2; K>=1 whenever FEED is active.
  assign k_ext     = CNT_W'(k_q);
  assign feed_last = k_ext + N_CNT - CNT_W'(2);

  // Next-state and counter update for the sequencing FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          k_d     = bus.k_len;
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end

      S_FEED: begin
        if (cnt_q == feed_last) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FLUSH: begin
        if (cnt_q == N_CNT - CNT_W'(1)) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        // c_ready only gates advancement; c_valid/c_row come from state.
        if (bus.c_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Skewed feed decode: row/column i is live for t in [i, i+K) with index t-i.
  always_comb begin
    feed_en_w  = '0;
    feed_idx_w = '0;
    if (state_q == S_FEED) begin
      for (int i = 0; i < ARRAY_N; i++) begin
        if ((cnt_q >= CNT_W'(i)) && (cnt_q < k_ext + CNT_W'(i))) begin
          feed_en_w[i]               = 1'b1;
          feed_idx_w[i*K_W +: K_W]   = K_W'(cnt_q - CNT_W'(i));
        end
      end
    end
  end

  // Outputs are decoded purely from registered state.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.pe_clear = (state_q == S_CLEAR);
  assign bus.feed_en  = feed_en_w;
  assign bus.feed_idx = feed_idx_w;
  assign bus.c_valid  = (state_q == S_DRAIN);
  assign bus.c_row    = row_q;

`ifdef GEMM_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;

  // Busy-cycle counter: cleared on accept, saturating, held while idle.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    if (start_acc) begin
      perf_cycles_d = '0;
    end else if ((state_q != S_IDLE) && (perf_cycles_q != '1)) begin
      perf_cycles_d = perf_cycles_q + 32'd1;
    end
  end

  // Perf counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
`else
  // Perf counter not built: no port and no logic.
`endif

endmodule
